// File: rtl/aesl_deadlock_stall_detector.sv
// Kernel deadlock detector: flags a block after THRESH consecutive stall cycles, blames the
// lowest-indexed stalled channel, and counts block entries since reset.
module aesl_deadlock_stall_detector #(
  parameter int unsigned NUM_AXIS = 2,
  parameter int unsigned NUM_INST = 1,
  parameter int unsigned THRESH   = 16,
  parameter int unsigned CNT_W    = 16,
  localparam int unsigned NUM_CH  = NUM_AXIS + NUM_INST,
  localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic [NUM_INST-1:0] inst_idle_sigs,
  input  logic [NUM_INST-1:0] inst_block_sigs,
  input  logic                clear,
  output logic                block,
  output logic [CH_W-1:0]     block_chan,
  output logic [CNT_W-1:0]    stall_cycles,
  output logic [7:0]          block_events
);

  typedef enum logic [1:0] {StIdle, StCount, StBlocked} state_e;

  localparam logic [CNT_W-1:0] CntMax = '1;

  state_e           r_state, w_state_nxt;
  logic             r_block, w_block_nxt;
  logic [CH_W-1:0]  r_chan, w_chan_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [7:0]       r_events, w_events_nxt;

  logic              w_stall;
  logic [NUM_CH-1:0] w_chans;
  logic [CH_W-1:0]   w_low_chan;
  logic [CNT_W-1:0]  w_cnt_inc;

  // Everything idle means the kernel is done, not deadlocked.
  assign w_stall   = (|axis_block_sigs | |inst_block_sigs) & ~(&inst_idle_sigs);
  assign w_chans   = {inst_block_sigs, axis_block_sigs};
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_comb begin
    w_low_chan = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_chans[i]) w_low_chan = CH_W'(i);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_block_nxt  = r_block;
    w_chan_nxt   = r_chan;
    w_cnt_nxt    = r_cnt;
    w_events_nxt = r_events;
    if (clear) begin
      // Re-arm wins over a block completing on the same edge.
      w_state_nxt = StIdle;
      w_block_nxt = 1'b0;
      w_chan_nxt  = '0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_stall) begin
            w_state_nxt = StCount;
            w_cnt_nxt   = CNT_W'(1);
          end else begin
            w_cnt_nxt = '0;
          end
        end
        StCount: begin
          if (!w_stall) begin
            w_state_nxt = StIdle;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == CNT_W'(THRESH)) begin
              w_state_nxt  = StBlocked;
              w_block_nxt  = 1'b1;
              w_chan_nxt   = w_low_chan;
              w_events_nxt = (r_events != 8'hFF) ? r_events + 8'd1 : r_events;
            end
          end
        end
        StBlocked: begin
          if (w_stall && (r_cnt != CntMax)) w_cnt_nxt = w_cnt_inc;
        end
        default: w_state_nxt = StIdle;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= StIdle;
      r_block  <= 1'b0;
      r_chan   <= '0;
      r_cnt    <= '0;
      r_events <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_block  <= w_block_nxt;
      r_chan   <= w_chan_nxt;
      r_cnt    <= w_cnt_nxt;
      r_events <= w_events_nxt;
    end
  end

  assign block        = r_block;
  assign block_chan   = r_chan;
  assign stall_cycles = r_cnt;
  assign block_events = r_events;

endmodule

// File: tb/tb_aesl_deadlock_stall_detector.sv
// Bench for aesl_deadlock_stall_detector: directed scenarios plus sticky random traffic,
// every cycle compared against a plain behavioural model.
module tb_aesl_deadlock_stall_detector;

  localparam int THRESH = 16;
  localparam int CMAX   = 65535;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] axis_block_sigs;
  logic [0:0] inst_idle_sigs;
  logic [0:0] inst_block_sigs;
  logic       clear;
  logic       block;
  logic [1:0] block_chan;
  logic [15:0] stall_cycles;
  logic [7:0] block_events;

  int vectors = 0;
  int miscompares = 0;

  // Model state: consecutive-stall run length, sticky flag, blamed channel, entry count.
  int m_cnt = 0;
  bit m_blk = 0;
  int m_chan = 0;
  int m_ev = 0;

  aesl_deadlock_stall_detector #(
    .NUM_AXIS(2), .NUM_INST(1), .THRESH(THRESH), .CNT_W(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs(inst_idle_sigs),
    .inst_block_sigs(inst_block_sigs),
    .clear(clear),
    .block(block),
    .block_chan(block_chan),
    .stall_cycles(stall_cycles),
    .block_events(block_events)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".block"}, {31'd0, block}, m_blk ? 32'd1 : 32'd0);
    check({tag, ".chan"}, {30'd0, block_chan}, m_chan);
    check({tag, ".cycles"}, {16'd0, stall_cycles}, m_cnt);
    check({tag, ".events"}, {24'd0, block_events}, m_ev);
  endtask

  function automatic int lowest(input logic [1:0] ax, input logic ib);
    for (int i = 0; i < 2; i++) if (ax[i]) return i;
    if (ib) return 2;
    return 0;
  endfunction

  task automatic model(input logic [1:0] ax, input logic ib, input logic idl, input logic clr);
    bit stall;
    stall = ((ax != 2'b00) || ib) && !idl;
    if (clr) begin
      m_blk = 0; m_cnt = 0; m_chan = 0;
    end else if (m_blk) begin
      if (stall && m_cnt < CMAX) m_cnt++;
    end else if (stall) begin
      m_cnt++;
      if (m_cnt == THRESH) begin
        m_blk = 1;
        m_chan = lowest(ax, ib);
        if (m_ev < 255) m_ev++;
      end
    end else begin
      m_cnt = 0;
    end
  endtask

  task automatic step(input string tag, input logic [1:0] ax, input logic ib, input logic idl,
                      input logic clr);
    axis_block_sigs = ax;
    inst_block_sigs = ib;
    inst_idle_sigs  = idl;
    clear           = clr;
    model(ax, ib, idl, clr);
    @(posedge clock);
    #1;
    check_all(tag);
  endtask

  // Asserted between edges so the asynchronous path is what gets checked.
  task automatic pulse_reset(input string tag);
    #3;
    reset = 1'b0;
    m_cnt = 0; m_blk = 0; m_chan = 0; m_ev = 0;
    #1;
    check_all(tag);
    #3;
    reset = 1'b1;
  endtask

  initial begin
    logic [1:0] ax;
    logic ib, idl;
    reset = 1'b0;
    axis_block_sigs = '0;
    inst_block_sigs = '0;
    inst_idle_sigs  = '0;
    clear = 1'b0;
    #12;
    check_all("reset_state");
    reset = 1'b1;

    // Single channel held: block on the 16th edge, blame channel 1.
    for (int i = 0; i < 16; i++) step("hold10", 2'b10, 1'b0, 1'b0, 1'b0);
    check("hold10_blk_const", {31'd0, block}, 32'd1);
    check("hold10_chan_const", {30'd0, block_chan}, 32'd1);
    check("hold10_ev_const", {24'd0, block_events}, 32'd1);
    check("hold10_cyc_const", {16'd0, stall_cycles}, 32'd16);
    step("blk_nostall", 2'b00, 1'b0, 1'b0, 1'b0);
    step("blk_stall", 2'b01, 1'b0, 1'b0, 1'b0);
    pulse_reset("rst1");

    // One-cycle gap fully restarts the count.
    for (int i = 0; i < 15; i++) step("run_a", 2'b01, 1'b0, 1'b0, 1'b0);
    step("gap", 2'b00, 1'b0, 1'b0, 1'b0);
    check("gap_cyc_const", {16'd0, stall_cycles}, 32'd0);
    for (int i = 0; i < 15; i++) step("run_b", 2'b01, 1'b0, 1'b0, 1'b0);
    check("run_b_blk_const", {31'd0, block}, 32'd0);

    // Blocked but idle instance is not a stall.
    step("gap2", 2'b00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step("idle_blk", 2'b00, 1'b1, 1'b1, 1'b0);
    check("idle_blk_cyc_const", {16'd0, stall_cycles}, 32'd0);
    pulse_reset("rst2");

    // Clear coincides with the second threshold completion.
    for (int i = 0; i < 16; i++) step("first_blk", 2'b01, 1'b0, 1'b0, 1'b0);
    step("clr", 2'b00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 15; i++) step("second", 2'b01, 1'b0, 1'b0, 1'b0);
    step("second_clr", 2'b01, 1'b0, 1'b0, 1'b1);
    check("clr_race_blk_const", {31'd0, block}, 32'd0);
    check("clr_race_ev_const", {24'd0, block_events}, 32'd1);
    pulse_reset("rst3");

    // All sources stalled: lowest index wins; then saturate the event count.
    for (int i = 0; i < 16; i++) step("all", 2'b11, 1'b1, 1'b0, 1'b0);
    check("all_chan_const", {30'd0, block_chan}, 32'd0);
    for (int k = 0; k < 300; k++) begin
      step("sat_clr", 2'b00, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 16; i++) step("sat", 2'b00, 1'b1, 1'b0, 1'b0);
    end
    check("sat_ev_const", {24'd0, block_events}, 32'd255);
    check("sat_chan_const", {30'd0, block_chan}, 32'd2);
    pulse_reset("rst4");

    // Async reset with block=1 and stall_cycles=20.
    for (int i = 0; i < 20; i++) step("pre_rst", 2'b10, 1'b0, 1'b0, 1'b0);
    check("pre_rst_cyc_const", {16'd0, stall_cycles}, 32'd20);
    pulse_reset("async_rst");
    check("async_rst_blk_const", {31'd0, block}, 32'd0);
    check("async_rst_cyc_const", {16'd0, stall_cycles}, 32'd0);
    step("post_rst", 2'b01, 1'b0, 1'b0, 1'b0);

    // Sticky random traffic with occasional clears and resets.
    ax = 2'b00; ib = 1'b0; idl = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 19) == 0) ax = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) ib = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 29) == 0) idl = 1'($urandom_range(0, 1));
      step("rand", ax, ib, idl, ($urandom_range(0, 63) == 0));
      if ($urandom_range(0, 499) == 0) pulse_reset("rand_rst");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aesl_deadlock_stall_detector.md
AESL_DEADLOCK_STALL_DETECTOR -- requirements
Module: aesl_deadlock_stall_detector

Interface
REQ-001 SHALL provide parameter NUM_AXIS, default 2, number of AXI-Stream blocking channels monitored.
REQ-002 SHALL provide parameter NUM_INST, default 1, number of sub-instance idle/block pairs.
REQ-003 SHALL provide parameter THRESH, default 16, consecutive stall cycles before block is declared; legal range 2..65535.
REQ-004 SHALL provide parameter CNT_W, default 16, width of stall_cycles.
REQ-005 SHALL have port clock, input, 1, sole clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port axis_block_sigs, input, NUM_AXIS, 1 = stream channel i stalled on TDATA handshake.
REQ-008 SHALL have port inst_idle_sigs, input, NUM_INST, 1 = sub-instance i idle.
REQ-009 SHALL have port inst_block_sigs, input, NUM_INST, 1 = sub-instance i blocked.
REQ-010 SHALL have port clear, input, 1, synchronous pulse that re-arms the detector.
REQ-011 SHALL have port block, output, 1, sticky kernel-deadlock flag.
REQ-012 SHALL have port block_chan, output, CH_W = max(1, clog2(NUM_AXIS+NUM_INST)), index of the channel blamed for the block.
REQ-013 SHALL have port stall_cycles, output, CNT_W, current consecutive stall count.
REQ-014 SHALL have port block_events, output, 8, number of block entries since reset.

Function
REQ-015 SHALL compute combinational stall = (|axis_block_sigs | |inst_block_sigs) & ~(&inst_idle_sigs).
REQ-016 SHALL implement FSM states IDLE, COUNT, BLOCKED.
REQ-017 IDLE: stall=1 -> COUNT, stall_cycles<=1; otherwise remain, stall_cycles=0.
REQ-018 COUNT: stall=0 -> IDLE, stall_cycles<=0; stall=1 -> stall_cycles<=stall_cycles+1.
REQ-019 COUNT: stall=1 and stall_cycles+1 == THRESH -> BLOCKED; block<=1 on that same edge, so block rises on the THRESH-th consecutive stall-sampling edge.
REQ-020 On BLOCKED entry SHALL capture block_chan = lowest set index of the vector {inst_block_sigs, axis_block_sigs}; axis channel i maps to index i, instance j to NUM_AXIS+j.
REQ-021 On BLOCKED entry SHALL increment block_events, saturating at 255.
REQ-022 BLOCKED: block stays 1 and block_chan stays frozen regardless of stall; stall_cycles keeps incrementing while stall=1, holds when stall=0, and saturates at 2^CNT_W-1.
REQ-023 clear=1 in any state SHALL, on that edge, force IDLE, block<=0, stall_cycles<=0, block_chan<=0; block_events is not cleared.
REQ-024 clear SHALL take precedence over a simultaneous COUNT->BLOCKED transition: no block entry and no block_events increment that cycle.
REQ-025 A single non-stall cycle in COUNT SHALL fully restart the count (no hysteresis).
REQ-026 All outputs SHALL be registered; no combinational input-to-output path.
REQ-027 stall_cycles in COUNT SHALL never exceed THRESH-1 before the BLOCKED transition.

Reset
REQ-028 reset=0 SHALL asynchronously force IDLE, block=0, block_chan=0, stall_cycles=0, block_events=0.
REQ-029 Reset asserted mid-COUNT or in BLOCKED SHALL discard all progress; counting restarts from 0 after release.
REQ-030 The first rising edge after reset deassertion SHALL evaluate stall normally.

Verification
REQ-031 axis_block_sigs=2'b10 held 16 cycles, THRESH=16 -> block=1 after the 16th edge, block_chan=1, block_events=1, stall_cycles=16.
REQ-032 axis_block_sigs=2'b01 for 15 cycles, 1 cycle 0, then 15 cycles 2'b01 -> block stays 0; stall_cycles returns to 0 at the gap.
REQ-033 inst_block_sigs=1 with inst_idle_sigs=1 for 40 cycles -> block=0, stall_cycles=0 throughout.
REQ-034 Block reached, then clear pulsed on the same edge as a second THRESH completion -> block=0, block_events unchanged at 1.
REQ-035 axis_block_sigs=2'b11 and inst_block_sigs=1 for 16 cycles -> block_chan=0; repeated block/clear 300 times -> block_events saturates at 255.
REQ-036 reset pulled low while block=1 and stall_cycles=20 -> all outputs 0 immediately, without waiting for a clock edge.
